// File: rtl/pe_sequencer_pkg.sv
// Shared constants for the PE instruction sequencer: opcodes, instruction
// field positions, FSM state encoding and the default WAIT timeout.
package pe_seq_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_MUL  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_NOT  = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int OP_LSB  = 12;
    localparam int RD_LSB  = 8;
    localparam int RS1_LSB = 4;
    localparam int RS2_LSB = 0;
    localparam int FIELD_W = 4;

    localparam int TIMEOUT_CYC_DEF = 15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } seq_state_e;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op <= OP_XOR);
    endfunction

endpackage

// File: rtl/pe_sequencer_if.sv
// Operand/instruction and result port between the sequencer (master) and
// the Tiny PE ALU (slave).
interface pe_sequencer_if;
    logic        alu_en_out;
    logic [7:0]  alu_ins_out;
    logic [15:0] alu_a_out;
    logic [15:0] alu_b_out;
    logic [15:0] alu_c_in;
    logic        alu_c_valid_in;

    modport master (
        output alu_en_out, alu_ins_out, alu_a_out, alu_b_out,
        input  alu_c_in, alu_c_valid_in
    );

    modport slave (
        input  alu_en_out, alu_ins_out, alu_a_out, alu_b_out,
        output alu_c_in, alu_c_valid_in
    );
endinterface

// File: rtl/pe_sequencer_regfile.sv
// 16-bit register file with two operand read ports, one host read port and a
// single write port shared by ALU writeback and host writes.
module pe_seq_regfile #(
    parameter int NREG = 16,
    parameter int AW   = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [15:0]   host_data,
    input  logic          wb_we,
    input  logic [AW-1:0] wb_addr,
    input  logic [15:0]   wb_data,
    input  logic [AW-1:0] raddr_a,
    input  logic [AW-1:0] raddr_b,
    input  logic [AW-1:0] raddr_h,
    output logic [15:0]   rdata_a,
    output logic [15:0]   rdata_b,
    output logic [15:0]   rdata_h
);

    logic [15:0] regs [NREG];

    // Writeback wins; the host is gated to IDLE upstream so they never meet.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wb_we) begin
            regs[wb_addr] <= wb_data;
        end else if (host_we) begin
            regs[host_addr] <= host_data;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];
    assign rdata_h = regs[raddr_h];

endmodule

// File: rtl/pe_sequencer.sv
// PE instruction sequencer: fetches from a host-loaded program memory, issues
// one ALU operation per instruction and writes the result back.
// Optional WAIT timeout is compiled in with PE_SEQ_TIMEOUT_EN.
//
// state | meaning
// IDLE  | host may load program/registers; waits for start_in
// FETCH | decode word at PC, latch rd/opcode/operands
// ISSUE | one-cycle alu_en_out pulse
// WAIT  | wait for alu_c_valid_in, write back, advance PC
// DONE  | one-cycle done_out pulse
module pe_sequencer
    import pe_seq_pkg::*;
#(
    parameter int IMEM_DEPTH  = 16,
    parameter int NREG        = 16,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          start_in,
    input  logic                          prog_we_in,
    input  logic [$clog2(IMEM_DEPTH)-1:0] prog_addr_in,
    input  logic [15:0]                   prog_data_in,
    input  logic                          rf_we_in,
    input  logic [3:0]                    rf_addr_in,
    input  logic [15:0]                   rf_wdata_in,
    input  logic [3:0]                    rf_raddr_in,
    output logic [15:0]                   rf_rdata_out,
    output logic                          busy_out,
    output logic                          done_out,
    output logic                          err_out,
    output logic [$clog2(IMEM_DEPTH)-1:0] pc_out,
    pe_sequencer_if.master                alu
);

    localparam int PCW = $clog2(IMEM_DEPTH);
    localparam logic [PCW-1:0] PC_LAST = PCW'(IMEM_DEPTH - 1);

    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 15) begin : g_bad_timeout
        $error("TIMEOUT_CYC must fit the 4-bit WAIT counter");
    end

    seq_state_e     state, state_nxt;
    logic [PCW-1:0] pc, pc_nxt;
    logic           err, err_nxt;
    logic           latch_en;
    logic           wb_we;

    logic [15:0]    imem [IMEM_DEPTH];
    logic [15:0]    instr;
    logic [3:0]     op, rd, rs1, rs2;
    logic [15:0]    rdata_a, rdata_b;

    logic [3:0]     rd_q;
    logic [7:0]     ins_q;
    logic [15:0]    a_q, b_q;

    assign instr = imem[pc];
    assign op    = instr[OP_LSB  +: FIELD_W];
    assign rd    = instr[RD_LSB  +: FIELD_W];
    assign rs1   = instr[RS1_LSB +: FIELD_W];
    assign rs2   = instr[RS2_LSB +: FIELD_W];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < IMEM_DEPTH; i++) imem[i] <= '0;
        end else if (prog_we_in && state == ST_IDLE) begin
            imem[prog_addr_in] <= prog_data_in;
        end
    end

    pe_seq_regfile #(.NREG(NREG), .AW(4)) u_rf (
        .CLK       (CLK),
        .RST       (RST),
        .host_we   (rf_we_in && state == ST_IDLE),
        .host_addr (rf_addr_in),
        .host_data (rf_wdata_in),
        .wb_we     (wb_we),
        .wb_addr   (rd_q),
        .wb_data   (alu.alu_c_in),
        .raddr_a   (rs1),
        .raddr_b   (rs2),
        .raddr_h   (rf_raddr_in),
        .rdata_a   (rdata_a),
        .rdata_b   (rdata_b),
        .rdata_h   (rf_rdata_out)
    );

`ifdef PE_SEQ_TIMEOUT_EN
    logic [3:0] tmr;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tmr <= '0;
        end else if (state == ST_ISSUE) begin
            tmr <= 4'(TIMEOUT_CYC - 1);
        end else if (state == ST_WAIT && tmr != '0) begin
            tmr <= tmr - 4'd1;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        err_nxt   = err;
        latch_en  = 1'b0;
        wb_we     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_in) begin
                    state_nxt = ST_FETCH;
                    pc_nxt    = '0;
                    err_nxt   = 1'b0;
                end
            end
            ST_FETCH: begin
                if (op == OP_HALT) begin
                    state_nxt = ST_DONE;
                end else if (!is_alu_op(op)) begin
                    err_nxt   = 1'b1;
                    state_nxt = ST_DONE;
                end else begin
                    latch_en  = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (alu.alu_c_valid_in) begin
                    wb_we = 1'b1;
                    if (pc == PC_LAST) begin
                        state_nxt = ST_DONE;
                    end else begin
                        pc_nxt    = pc + PCW'(1);
                        state_nxt = ST_FETCH;
                    end
                end
`ifdef PE_SEQ_TIMEOUT_EN
                else if (tmr == '0) begin
                    err_nxt   = 1'b1;
                    state_nxt = ST_DONE;
                end
`endif
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Operand/instruction registers double as the held ALU outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= ST_IDLE;
            pc    <= '0;
            err   <= 1'b0;
            rd_q  <= '0;
            ins_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            err   <= err_nxt;
            if (latch_en) begin
                rd_q  <= rd;
                ins_q <= {4'b0, op};
                a_q   <= rdata_a;
                b_q   <= rdata_b;
            end
        end
    end

    assign busy_out        = (state != ST_IDLE);
    assign done_out        = (state == ST_DONE);
    assign err_out         = err;
    assign pc_out          = pc;
    assign alu.alu_en_out  = (state == ST_ISSUE);
    assign alu.alu_ins_out = ins_q;
    assign alu.alu_a_out   = a_q;
    assign alu.alu_b_out   = b_q;

endmodule

// File: tb/tb_pe_sequencer.sv
// Directed bench for pe_sequencer with a behavioural 1-cycle ALU and an
// issue scoreboard; covers the PE_SEQ_TIMEOUT_EN build when that macro is set.
module tb_pe_sequencer;
    import pe_seq_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        start_in = 1'b0;
    logic        prog_we_in = 1'b0;
    logic [3:0]  prog_addr_in = '0;
    logic [15:0] prog_data_in = '0;
    logic        rf_we_in = 1'b0;
    logic [3:0]  rf_addr_in = '0;
    logic [15:0] rf_wdata_in = '0;
    logic [3:0]  rf_raddr_in = '0;
    logic [15:0] rf_rdata_out;
    logic        busy_out, done_out, err_out;
    logic [3:0]  pc_out;

    logic        mute = 1'b0;
    logic        inj = 1'b0;
    logic [15:0] inj_val = '0;

    typedef struct packed {
        logic [7:0]  ins;
        logic [15:0] a;
        logic [15:0] b;
    } issue_t;

    issue_t exp_q[$];
    int n_pass = 0;
    int n_checks = 0;
    int n_issue = 0;

    always #5 CLK = ~CLK;

    pe_sequencer_if alu_bus ();

    pe_sequencer dut (
        .CLK          (CLK),
        .RST          (RST),
        .start_in     (start_in),
        .prog_we_in   (prog_we_in),
        .prog_addr_in (prog_addr_in),
        .prog_data_in (prog_data_in),
        .rf_we_in     (rf_we_in),
        .rf_addr_in   (rf_addr_in),
        .rf_wdata_in  (rf_wdata_in),
        .rf_raddr_in  (rf_raddr_in),
        .rf_rdata_out (rf_rdata_out),
        .busy_out     (busy_out),
        .done_out     (done_out),
        .err_out      (err_out),
        .pc_out       (pc_out),
        .alu          (alu_bus)
    );

    function automatic logic [15:0] alu_model(input logic [7:0] ins,
                                              input logic [15:0] a,
                                              input logic [15:0] b);
        logic signed [31:0] p;
        p = $signed(a) * $signed(b);
        case (ins[3:0])
            OP_NOP:  return a;
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_MUL:  return p[22:7];
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_NOT:  return ~a;
            OP_XOR:  return a ^ b;
            default: return 16'h0000;
        endcase
    endfunction

    // Behavioural ALU: result one cycle after alu_en; mute/inj let the bench
    // withhold or force a result.
    always @(posedge CLK) begin
        alu_bus.alu_c_valid_in <= (alu_bus.alu_en_out && !mute) || inj;
        alu_bus.alu_c_in <= inj ? inj_val
                          : alu_model(alu_bus.alu_ins_out, alu_bus.alu_a_out, alu_bus.alu_b_out);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    always @(negedge CLK) begin
        if (alu_bus.alu_en_out === 1'b1) begin
            issue_t e;
            n_issue++;
            chk("issue_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("issue_ins", 32'(alu_bus.alu_ins_out), 32'(e.ins));
                chk("issue_a", 32'(alu_bus.alu_a_out), 32'(e.a));
                chk("issue_b", 32'(alu_bus.alu_b_out), 32'(e.b));
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr_reg(input logic [3:0] a, input logic [15:0] d);
        rf_we_in = 1'b1; rf_addr_in = a; rf_wdata_in = d;
        tick();
        rf_we_in = 1'b0;
    endtask

    task automatic wr_prog(input logic [3:0] a, input logic [15:0] d);
        prog_we_in = 1'b1; prog_addr_in = a; prog_data_in = d;
        tick();
        prog_we_in = 1'b0;
    endtask

    task automatic chk_reg(input string tag, input logic [3:0] a, input logic [15:0] exp);
        rf_raddr_in = a;
        #1;
        chk(tag, 32'(rf_rdata_out), 32'(exp));
    endtask

    // Cycles counted from the start-acceptance cycle up to and including DONE.
    task automatic run(input int limit, output int cyc);
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        cyc = 1;
        while (done_out !== 1'b1 && cyc < limit) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int iss0;
        int k;

        tick(); tick();
        RST = 1'b1;
        tick();

        chk("rst_busy", 32'(busy_out), 0);
        chk("rst_done", 32'(done_out), 0);
        chk("rst_err", 32'(err_out), 0);
        chk("rst_pc", 32'(pc_out), 0);
        chk("rst_alu_en", 32'(alu_bus.alu_en_out), 0);
        chk("rst_alu_ins", 32'(alu_bus.alu_ins_out), 0);
        chk("rst_alu_a", 32'(alu_bus.alu_a_out), 0);
        chk_reg("rst_r7", 4'd7, 16'h0000);

        // ADD r2,r0,r1 ; HALT
        wr_reg(4'd0, 16'h0080);
        wr_reg(4'd1, 16'h0100);
        wr_prog(4'd0, 16'h1201);
        wr_prog(4'd1, 16'hF000);
        exp_q.push_back('{ins: 8'h01, a: 16'h0080, b: 16'h0100});
        iss0 = n_issue;
        run(100, cyc);
        chk("add_latency", 32'(cyc), 32'd5);
        chk("add_err", 32'(err_out), 0);
        tick();
        chk("add_done_one_cycle", 32'(done_out), 0);
        chk("add_idle", 32'(busy_out), 0);
        chk("add_issue_count", 32'(n_issue - iss0), 32'd1);
        chk_reg("add_r2", 4'd2, 16'h0180);
        chk("hold_ins", 32'(alu_bus.alu_ins_out), 32'h01);
        chk("hold_a", 32'(alu_bus.alu_a_out), 32'h0080);
        chk("hold_b", 32'(alu_bus.alu_b_out), 32'h0100);

        // MUL r1,r0,r0 ; SUB r2,r1,r0 ; HALT
        wr_reg(4'd0, 16'h0100);
        wr_prog(4'd0, 16'h3100);
        wr_prog(4'd1, 16'h2210);
        wr_prog(4'd2, 16'hF000);
        exp_q.push_back('{ins: 8'h03, a: 16'h0100, b: 16'h0100});
        exp_q.push_back('{ins: 8'h02, a: 16'h0200, b: 16'h0100});
        run(100, cyc);
        chk("chain_latency", 32'(cyc), 32'd8);
        tick();
        chk_reg("chain_r1", 4'd1, 16'h0200);
        chk_reg("chain_r2", 4'd2, 16'h0100);

        // Illegal opcode 0x8123
        wr_prog(4'd0, 16'h8123);
        iss0 = n_issue;
        run(100, cyc);
        chk("ill_latency", 32'(cyc), 32'd2);
        chk("ill_err", 32'(err_out), 1);
        tick();
        chk("ill_err_sticky", 32'(err_out), 1);
        chk("ill_no_issue", 32'(n_issue - iss0), 0);
        chk_reg("ill_r1_kept", 4'd1, 16'h0200);
        wr_prog(4'd0, 16'hF000);
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        chk("ill_err_cleared", 32'(err_out), 0);
        tick();
        chk("halt_done", 32'(done_out), 1);
        tick();

        // 16 x NOP r1,r0,r0, no HALT
        wr_reg(4'd0, 16'h1234);
        for (int i = 0; i < 16; i++) begin
            wr_prog(4'(i), 16'h0100);
            exp_q.push_back('{ins: 8'h00, a: 16'h1234, b: 16'h1234});
        end
        run(200, cyc);
        chk("full_latency", 32'(cyc), 32'd49);
        chk("full_pc_last", 32'(pc_out), 32'd15);
        tick();
        chk("full_pc_no_wrap", 32'(pc_out), 32'd15);
        chk("full_idle", 32'(busy_out), 0);
        chk_reg("full_r1", 4'd1, 16'h1234);

        // Host strobes and start while in WAIT
        wr_prog(4'd0, 16'h1200);
        wr_prog(4'd1, 16'hF000);
        mute = 1'b1;
        exp_q.push_back('{ins: 8'h01, a: 16'h1234, b: 16'h1234});
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        tick(); tick();
        rf_we_in = 1'b1; rf_addr_in = 4'd5; rf_wdata_in = 16'hBEEF;
        prog_we_in = 1'b1; prog_addr_in = 4'd1; prog_data_in = 16'h8000;
        start_in = 1'b1;
        tick();
        rf_we_in = 1'b0; prog_we_in = 1'b0; start_in = 1'b0;
        chk("busy_wait_busy", 32'(busy_out), 1);
        chk("busy_pc_hold", 32'(pc_out), 0);
        inj = 1'b1; inj_val = 16'h7777;
        tick();
        inj = 1'b0;
        k = 0;
        while (done_out !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        chk("busy_done", 32'(done_out), 1);
        chk("busy_pc_end", 32'(pc_out), 1);
        chk("busy_err", 32'(err_out), 0);
        tick();
        chk_reg("busy_r2_wb", 4'd2, 16'h7777);
        chk_reg("busy_r5_kept", 4'd5, 16'h0000);

        // Withheld ALU result
        wr_prog(4'd0, 16'h1300);
        exp_q.push_back('{ins: 8'h01, a: 16'h1234, b: 16'h1234});
`ifdef PE_SEQ_TIMEOUT_EN
        run(60, cyc);
        chk("to_latency", 32'(cyc), 32'd18);
        chk("to_err", 32'(err_out), 1);
        tick();
        chk_reg("to_r3_kept", 4'd3, 16'h0000);
        exp_q.push_back('{ins: 8'h01, a: 16'h1234, b: 16'h1234});
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        tick(); tick();
`else
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        tick(); tick();
        repeat (30) tick();
        chk("hang_busy", 32'(busy_out), 1);
        chk("hang_done", 32'(done_out), 0);
        chk("hang_err", 32'(err_out), 0);
`endif

        // Reset in the middle of a run
        RST = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy_out), 0);
        chk("mid_rst_done", 32'(done_out), 0);
        chk("mid_rst_err", 32'(err_out), 0);
        chk("mid_rst_pc", 32'(pc_out), 0);
        chk("mid_rst_alu_en", 32'(alu_bus.alu_en_out), 0);
        chk_reg("mid_rst_r0", 4'd0, 16'h0000);
        chk_reg("mid_rst_r1", 4'd1, 16'h0000);
        chk_reg("mid_rst_r2", 4'd2, 16'h0000);
        tick();
        RST = 1'b1;
        mute = 1'b0;
        tick();

        // Cleared program memory runs as 16 x NOP r0,r0,r0
        for (int i = 0; i < 16; i++)
            exp_q.push_back('{ins: 8'h00, a: 16'h0000, b: 16'h0000});
        run(200, cyc);
        chk("clr_latency", 32'(cyc), 32'd49);
        tick();
        chk("queue_drained", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pe_sequencer.md
# pe_sequencer

Instruction sequencer that drives the Tiny PE ALU's operand/instruction port and consumes its result port. It holds a 16-entry program memory and a 16 × 16-bit Q8.7 register file, both loaded by the host while idle. On start, it fetches each instruction, issues one ALU operation, waits for the result, writes it back, and stops on HALT, an illegal opcode or the end of memory. It sits between the host interface and the ALU inside the PE.

## Interface
Parameters:
- IMEM_DEPTH, 16: program words; PC width is log2(IMEM_DEPTH).
- NREG, 16: register-file entries; fixed by the 4-bit register fields.
- TIMEOUT_CYC, 15: maximum WAIT cycles when the timeout feature is compiled in.

Ports. Reset is RST, asynchronous, active-low; clock is CLK.
- CLK  in  1  clock
- RST  in  1  asynchronous active-low reset
- start_in  in  1  start execution at PC 0; honoured only in IDLE
- prog_we_in  in  1  program-memory write strobe; ignored unless IDLE
- prog_addr_in  in  4  program-memory write address
- prog_data_in  in  16  instruction word
- rf_we_in  in  1  host register write strobe; ignored unless IDLE
- rf_addr_in  in  4  host register write address
- rf_wdata_in  in  16  host register write data
- rf_raddr_in  in  4  host register read address
- rf_rdata_out  out  16  combinational read of reg[rf_raddr_in]
- busy_out  out  1  high in every state except IDLE
- done_out  out  1  one-cycle pulse when execution ends
- err_out  out  1  sticky error flag; cleared by an accepted start
- pc_out  out  4  current PC
- alu_en_out  out  1  ALU enable; one-cycle pulse per instruction
- alu_ins_out  out  8  ALU instruction, {4'b0, opcode}
- alu_a_out  out  16  operand A, reg[rs1]
- alu_b_out  out  16  operand B, reg[rs2]
- alu_c_in  in  16  ALU result
- alu_c_valid_in  in  1  ALU result valid

## Operation
- Instruction format: [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2.
- Opcode map:
  - 0 NOP, 1 ADD, 2 SUB, 3 MUL, 4 AND, 5 OR, 6 NOT, 7 XOR. These match the ALU encoding.
  - 4'hF HALT.
  - 8–E are illegal.
- FSM states: IDLE, FETCH, ISSUE, WAIT, DONE.
- IDLE:
  - Host writes are accepted here.
  - start_in moves to FETCH, sets PC=0 and clears err_out.
- FETCH:
  - Latches the instruction at PC, plus reg[rs1] and reg[rs2], into operand registers.
  - HALT goes to DONE.
  - An illegal opcode sets err_out and goes to DONE.
  - Any other opcode goes to ISSUE.
- ISSUE:
  - alu_en_out=1 for exactly one cycle.
  - ins/a/b are driven from the latched registers.
  - Goes to WAIT.
- WAIT:
  - On alu_c_valid_in=1, writes reg[rd] ← alu_c_in.
  - If PC is the last address, goes to DONE; otherwise PC+1 and goes to FETCH.
  - PC never wraps.
- DONE: done_out=1 for one cycle, then IDLE.
- Writeback takes priority over host writes; host writes can only happen in IDLE, so the two never collide.
- rd may equal rs1 or rs2: operands were latched in FETCH, so the writeback is safe.
- The block performs no arithmetic; results are stored exactly as returned by the ALU (Q8.7).
- alu_ins_out, alu_a_out and alu_b_out hold their last values outside ISSUE.

## Timing
- Reset values:
  - All outputs 0; state IDLE; PC 0.
  - Register file and program memory are cleared to 0.
- Per-instruction latency with the 1-cycle ALU is 3 cycles: FETCH, ISSUE, WAIT.
  - An N-instruction program plus HALT takes 3N+2 cycles from start acceptance to the done_out pulse.
- start_in asserted while busy: ignored.
- Host strobes while busy: ignored.
- alu_c_valid_in outside WAIT: ignored.
- RST mid-program: immediate return to IDLE. Memories clear, no done_out pulse, err_out=0.

## Configuration
- Macro: PE_SEQ_TIMEOUT_EN.
- Defined:
  - A 4-bit WAIT counter is compiled in.
  - If TIMEOUT_CYC cycles pass in WAIT without alu_c_valid_in, err_out is set, no writeback occurs, and the FSM goes to DONE.
- Undefined: WAIT holds indefinitely; no counter logic exists.

## Structure
- Package pe_seq_pkg contains:
  - opcode constants (NOP..XOR, HALT);
  - the state encoding;
  - instruction field bit positions;
  - TIMEOUT_CYC default.
- Sub-module pe_seq_regfile: 16 × 16 flops with two read ports for operands, one host read port, and one write port. The write port is muxed between the host (IDLE) and writeback (WAIT).
- Program memory is inline flops in pe_sequencer.

## Test plan
- ADD: r0=0x0080, r1=0x0100; program ADD r2,r0,r1 then HALT; start.
  - Required: r2=0x0180.
  - done_out pulses 5 cycles after start.
  - alu_en_out is high for exactly one cycle.
- MUL/SUB chain: r0=0x0100.
  - Program MUL r1,r0,r0; SUB r2,r1,r0; HALT.
  - Required: r1=0x0200 and r2=0x0100.
- Illegal opcode: program word 0x8123.
  - Required: err_out=1, done_out pulse, no register change, alu_en_out never asserted.
  - A following accepted start clears err_out.
- Full program: 16 NOP r1,r0,r0 with no HALT, r0=0x1234.
  - Required: r1=0x1234.
  - done_out pulses after PC 15, and PC does not wrap.
- Busy protection and reset:
  - rf_we_in, prog_we_in and start_in pulsed in WAIT → no effect.
  - RST pulsed mid-run → IDLE, busy_out=0, all registers 0.
- PE_SEQ_TIMEOUT_EN build: hold alu_c_valid_in=0.
  - Required: err_out=1 after 15 WAIT cycles, rd unchanged.
  - In the build without the macro, busy_out stays high.
